l2cache_axi_bridge: RTL

- Memory-side responder for the L2 cache line interface (req/addrOK/dataOK), translating each request into one AXI4 INCR burst.
- Reads fetch a whole line beat by beat and return it to the cache.
- Writes take a whole victim line from the cache and stream it out.
- Sits between the L2 cache and the SoC AXI interconnect; one transaction outstanding at a time.

---
 rtl/l2cache_axi_bridge.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/l2cache_axi_bridge.sv
// l2cache_axi_bridge
//   Memory-side responder for the L2 cache line interface. Each accepted
//   request becomes one AXI4 INCR burst of (1<<offset_width) 32-bit beats.
//   Reads gather a whole line into the line buffer. Writes stream a latched
//   victim line. Only one transaction is in flight at a time.
//
// Ports
//   clk, rstn                     clock, asynchronous active-low reset
//   l2cache_mem_req_r/_w          cache read / write request
//   addr_l2cache_mem_r/_w         line-aligned read / write address
//   dout_l2cache_mem              write line (word 0 in bits [31:0])
//   l2cache_mem_wstrb             byte strobe applied to every write beat
//   mem_l2cache_addrOK_r/_w       one-cycle request-accepted pulses
//   din_mem_l2cache               read line to the cache
//   mem_l2cache_dataOK            read data valid / write complete
//   l2cache_mem_rdy               cache accepts dataOK
//   ar*/r*/aw*/w*/b*              AXI4 master channels
//
// offset_width must be at least 1.
module l2cache_axi_bridge #(
  parameter int unsigned offset_width = 2,
  parameter logic [3:0]  axi_id       = 4'd0
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  // cache read request
  input  logic                                 l2cache_mem_req_r,
  input  logic [31:0]                          addr_l2cache_mem_r,
  output logic                                 mem_l2cache_addrOK_r,
  // cache write request
  input  logic                                 l2cache_mem_req_w,
  input  logic [31:0]                          addr_l2cache_mem_w,
  input  logic [32*(1<<offset_width)-1:0]      dout_l2cache_mem,
  input  logic [3:0]                           l2cache_mem_wstrb,
  output logic                                 mem_l2cache_addrOK_w,
  // cache response
  output logic [32*(1<<offset_width)-1:0]      din_mem_l2cache,
  output logic                                 mem_l2cache_dataOK,
  input  logic                                 l2cache_mem_rdy,
  // AXI AR
  output logic [3:0]                           arid,
  output logic [31:0]                          araddr,
  output logic [7:0]                           arlen,
  output logic [2:0]                           arsize,
  output logic [1:0]                           arburst,
  output logic                                 arvalid,
  input  logic                                 arready,
  // AXI R
  input  logic [3:0]                           rid,
  input  logic [31:0]                          rdata,
  input  logic [1:0]                           rresp,
  input  logic                                 rlast,
  input  logic                                 rvalid,
  output logic                                 rready,
  // AXI AW
  output logic [3:0]                           awid,
  output logic [31:0]                          awaddr,
  output logic [7:0]                           awlen,
  output logic [2:0]                           awsize,
  output logic [1:0]                           awburst,
  output logic                                 awvalid,
  input  logic                                 awready,
  // AXI W
  output logic [31:0]                          wdata,
  output logic [3:0]                           wstrb,
  output logic                                 wlast,
  output logic                                 wvalid,
  input  logic                                 wready,
  // AXI B
  input  logic [3:0]                           bid,
  input  logic [1:0]                           bresp,
  input  logic                                 bvalid,
  output logic                                 bready
);

  localparam int unsigned BEATS = 1 << offset_width;
  localparam logic [offset_width-1:0] LAST = '1;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AW,
    W,
    B,
    RESP
  } state_t;

  state_t                        state;
  logic [offset_width-1:0]       cnt;
  logic [31:0]                   addr_q;
  logic [3:0]                    strb_q;
  logic [BEATS-1:0][31:0]        line_buf;
  logic [BEATS-1:0][31:0]        wline;

  // Response IDs and status codes are not inspected.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, bid, bresp};

  // Fixed burst shape
  assign arid    = axi_id;
  assign awid    = axi_id;
  assign arlen   = 8'(BEATS - 1);
  assign awlen   = 8'(BEATS - 1);
  assign arsize  = 3'b010;
  assign awsize  = 3'b010;
  assign arburst = 2'b01;
  assign awburst = 2'b01;

  assign araddr          = addr_q;
  assign awaddr          = addr_q;
  assign wstrb           = strb_q;
  assign wdata           = wline[cnt];
  assign wlast           = wvalid && (cnt == LAST);
  assign din_mem_l2cache = line_buf;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                <= IDLE;
      cnt                  <= '0;
      addr_q               <= '0;
      strb_q               <= '0;
      line_buf             <= '0;
      wline                <= '0;
      mem_l2cache_addrOK_r <= 1'b0;
      mem_l2cache_addrOK_w <= 1'b0;
      mem_l2cache_dataOK   <= 1'b0;
      arvalid              <= 1'b0;
      rready               <= 1'b0;
      awvalid              <= 1'b0;
      wvalid               <= 1'b0;
      bready               <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // write wins when both requests are present
          if (l2cache_mem_req_w) begin
            addr_q               <= addr_l2cache_mem_w;
            wline                <= dout_l2cache_mem;
            strb_q               <= l2cache_mem_wstrb;
            mem_l2cache_addrOK_w <= 1'b1;
            awvalid              <= 1'b1;
            state                <= AW;
          end else if (l2cache_mem_req_r) begin
            addr_q               <= addr_l2cache_mem_r;
            mem_l2cache_addrOK_r <= 1'b1;
            arvalid              <= 1'b1;
            state                <= AR;
          end
        end

        AR: begin
          mem_l2cache_addrOK_r <= 1'b0;
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            cnt     <= '0;
            state   <= R;
          end
        end

        R: begin
          if (rvalid) begin
            line_buf[cnt] <= rdata;
            cnt           <= cnt + 1'b1;
            // rlast ends the burst regardless of how many beats arrived
            if (rlast) begin
              rready             <= 1'b0;
              mem_l2cache_dataOK <= 1'b1;
              state              <= RESP;
            end
          end
        end

        AW: begin
          mem_l2cache_addrOK_w <= 1'b0;
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            cnt     <= '0;
            state   <= W;
          end
        end

        W: begin
          if (wready) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              wvalid <= 1'b0;
              bready <= 1'b1;
              state  <= B;
            end
          end
        end

        B: begin
          if (bvalid) begin
            bready             <= 1'b0;
            mem_l2cache_dataOK <= 1'b1;
            state              <= RESP;
          end
        end

        RESP: begin
          if (l2cache_mem_rdy) begin
            mem_l2cache_dataOK <= 1'b0;
            state              <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
